// File: rtl/fp16_to_fixed.sv
// IEEE-754 half to signed fixed-point converter, 2-stage pipeline with ready/valid flow control.
// Define FP16_ROUND_NEAREST_EN for round-to-nearest-even; otherwise the magnitude is truncated.
module fp16_to_fixed #(
    parameter int OUT_W     = 16,
    parameter int FRAC_BITS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    output logic             out_nan
);

    localparam int STAGES = 2;
    // Wide enough for the largest left shift: 11-bit mantissa << (5 + 30).
    localparam int MAG_W  = 48;
    localparam logic signed [7:0] S_OFS   = 8'(FRAC_BITS - 25);
    localparam logic [MAG_W-1:0]  NEG_LIM = MAG_W'(1) << (OUT_W - 1);
    localparam logic [MAG_W-1:0]  POS_LIM = NEG_LIM - MAG_W'(1);

    typedef struct packed {
        logic             sign;
        logic             nan;
        logic             inf;
        logic [MAG_W-1:0] mag;
`ifdef FP16_ROUND_NEAREST_EN
        logic             grd;
        logic             stk;
`endif
    } s1_t;

    logic              advance;
    logic [STAGES:1]   vld_pipe_d, vld_pipe_q;
    s1_t               s1_d, s1_q;
    logic [OUT_W-1:0]  out_data_d, out_data_q;
    logic              out_sat_d, out_sat_q;
    logic              out_nan_d, out_nan_q;

    logic [4:0]        exp_f, e_eff, rsh;
    logic [9:0]        frac_f;
    logic [10:0]       mant;
    logic signed [7:0] sh;
`ifdef FP16_ROUND_NEAREST_EN
    logic [36:0]       aligned;
    logic              round_up;
`endif
    logic [MAG_W-1:0]  mag_r;
    logic              over;

    assign advance   = ~vld_pipe_q[STAGES] | out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_pipe_q[STAGES];
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign out_nan   = out_nan_q;

    always_comb begin
        vld_pipe_d = {vld_pipe_q[STAGES-1:1], in_valid};
    end

    // S1: decode and align the significand to the output binary point.
    always_comb begin
        exp_f  = in_data[14:10];
        frac_f = in_data[9:0];
        mant   = {exp_f != 5'd0, frac_f};
        e_eff  = (exp_f == 5'd0) ? 5'd1 : exp_f;
        sh     = $signed({3'b000, e_eff}) + S_OFS;
        rsh    = 5'(-sh);
        s1_d      = '0;
        s1_d.sign = in_data[15];
        s1_d.nan  = (exp_f == 5'h1f) && (frac_f != 10'd0);
        s1_d.inf  = (exp_f == 5'h1f) && (frac_f == 10'd0);
`ifdef FP16_ROUND_NEAREST_EN
        aligned = {mant, 26'd0} >> rsh;
`endif
        if (exp_f == 5'h1f) begin
            s1_d.mag = '0;
        end else if (!sh[7]) begin
            s1_d.mag = MAG_W'(mant) << sh[5:0];
        end else begin
`ifdef FP16_ROUND_NEAREST_EN
            s1_d.mag = MAG_W'(aligned[36:26]);
            s1_d.grd = aligned[25];
            s1_d.stk = |aligned[24:0];
`else
            s1_d.mag = MAG_W'(mant >> rsh);
`endif
        end
    end

    // S2: round the magnitude, saturate, then negate so rounding is symmetric about zero.
    always_comb begin
`ifdef FP16_ROUND_NEAREST_EN
        round_up = s1_q.grd & (s1_q.stk | s1_q.mag[0]);
        mag_r    = s1_q.mag + MAG_W'(round_up);
`else
        mag_r    = s1_q.mag;
`endif
        over       = s1_q.sign ? (mag_r > NEG_LIM) : (mag_r > POS_LIM);
        out_data_d = '0;
        out_sat_d  = 1'b0;
        out_nan_d  = 1'b0;
        if (s1_q.nan) begin
            out_nan_d = 1'b1;
        end else if (s1_q.inf || over) begin
            out_sat_d  = 1'b1;
            out_data_d = s1_q.sign ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
            out_data_d = s1_q.sign ? -mag_r[OUT_W-1:0] : mag_r[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            s1_q       <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
            out_nan_q  <= 1'b0;
        end else if (advance) begin
            vld_pipe_q <= vld_pipe_d;
            s1_q       <= s1_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
            out_nan_q  <= out_nan_d;
        end
    end

endmodule

// File: tb/tb_fp16_to_fixed.sv
// Scoreboard bench for fp16_to_fixed: expectations queued at accept, compared at output transfer.
module tb_fp16_to_fixed;

    localparam int OUT_W = 16;
    localparam int FB    = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [15:0]      in_data = 16'd0;
    logic             in_ready, out_valid, out_sat, out_nan;
    logic [OUT_W-1:0] out_data;

    fp16_to_fixed #(.OUT_W(OUT_W), .FRAC_BITS(FB)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat), .out_nan(out_nan)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             sat;
        logic             nan;
    } res_t;

    res_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic acc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic res_t mk(input logic [OUT_W-1:0] d, input logic s, input logic n);
        res_t r;
        r.data = d; r.sat = s; r.nan = n;
        return r;
    endfunction

    // Real-valued reference: exact for half inputs at these output widths.
    function automatic res_t model(input logic [15:0] h);
        res_t  r;
        int    e, ee;
        real   m, v, fl, fr;
        longint q;
        r = '0;
        e = int'(h[14:10]);
        if (e == 31) begin
            if (h[9:0] != 10'd0) r.nan = 1'b1;
            else begin
                r.sat  = 1'b1;
                r.data = h[15] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
            end
            return r;
        end
        m  = (e == 0) ? real'(h[9:0]) : real'(1024 + int'(h[9:0]));
        ee = (e == 0) ? 1 : e;
        v  = m * (2.0 ** (ee - 25 + FB));
        fl = $floor(v);
        fr = v - fl;
`ifdef FP16_ROUND_NEAREST_EN
        if (fr > 0.5 || (fr == 0.5 && ($floor(fl / 2.0) * 2.0 != fl))) fl = fl + 1.0;
`endif
        if ((!h[15] && fl > (2.0 ** (OUT_W - 1)) - 1.0) || (h[15] && fl > 2.0 ** (OUT_W - 1))) begin
            r.sat  = 1'b1;
            r.data = h[15] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
            return r;
        end
        q = longint'(fl);
        if (h[15]) q = -q;
        r.data = q[OUT_W-1:0];
        return r;
    endfunction

    // One cycle: drive at the falling edge, then book the handshakes that the next rising edge commits.
    task automatic step(input logic v, input logic [15:0] d, input logic ordy,
                        input logic use_exp = 1'b0, input res_t e = '0);
        res_t r;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("unexpected_out", out_valid, 1'b0);
            else begin
                r = sb.pop_front();
                chk("out_data", out_data, r.data);
                chk("out_sat", out_sat, r.sat);
                chk("out_nan", out_nan, r.nan);
            end
        end
        acc = in_valid && in_ready;
        if (acc) sb.push_back(use_exp ? e : model(d));
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 50) begin
            step(1'b0, 16'd0, 1'b1);
            k++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    logic [15:0] bp_vals [4];
    int          idx;

    initial begin
        bp_vals[0] = 16'h3C00; bp_vals[1] = 16'h4000; bp_vals[2] = 16'h4200; bp_vals[3] = 16'h4400;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_data", out_data, 0);
        chk("rst_flags", {out_sat, out_nan}, 2'b00);
        rst_n = 1'b1;

        // 1.0 then -5.0 back to back, with latency checks.
        step(1'b1, 16'h3C00, 1'b1, 1'b1, mk(16'h0100, 1'b0, 1'b0));
        step(1'b1, 16'hC500, 1'b1, 1'b1, mk(16'hFB00, 1'b0, 1'b0));
        chk("lat_one_edge", out_valid, 1'b0);
        step(1'b0, 16'h0000, 1'b1);
        chk("lat_two_edges", out_valid, 1'b1);
        drain();

        // Saturation and its boundaries.
        step(1'b1, 16'h5C00, 1'b1, 1'b1, mk(16'h7FFF, 1'b1, 1'b0));
        step(1'b1, 16'hDC00, 1'b1, 1'b1, mk(16'h8000, 1'b1, 1'b0));
        step(1'b1, 16'h7C00, 1'b1, 1'b1, mk(16'h7FFF, 1'b1, 1'b0));
        step(1'b1, 16'hFC00, 1'b1, 1'b1, mk(16'h8000, 1'b1, 1'b0));
        step(1'b1, 16'hD800, 1'b1, 1'b1, mk(16'h8000, 1'b0, 1'b0));
        step(1'b1, 16'h57FF, 1'b1, 1'b1, mk(16'h7FF0, 1'b0, 1'b0));
        // NaN, zeros, underflowing subnormal.
        step(1'b1, 16'h7E00, 1'b1, 1'b1, mk(16'h0000, 1'b0, 1'b1));
        step(1'b1, 16'h8000, 1'b1, 1'b1, mk(16'h0000, 1'b0, 1'b0));
        step(1'b1, 16'h0000, 1'b1, 1'b1, mk(16'h0000, 1'b0, 1'b0));
        step(1'b1, 16'h0001, 1'b1, 1'b1, mk(16'h0000, 1'b0, 1'b0));
        // Rounding of sub-LSB fractions, including a negative tie.
`ifdef FP16_ROUND_NEAREST_EN
        step(1'b1, 16'h1A00, 1'b1, 1'b1, mk(16'h0001, 1'b0, 1'b0));
        step(1'b1, 16'h1800, 1'b1, 1'b1, mk(16'h0000, 1'b0, 1'b0));
        step(1'b1, 16'h1E00, 1'b1, 1'b1, mk(16'h0002, 1'b0, 1'b0));
        step(1'b1, 16'h9E00, 1'b1, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
`else
        step(1'b1, 16'h1A00, 1'b1, 1'b1, mk(16'h0000, 1'b0, 1'b0));
        step(1'b1, 16'h1800, 1'b1, 1'b1, mk(16'h0000, 1'b0, 1'b0));
        step(1'b1, 16'h1E00, 1'b1, 1'b1, mk(16'h0001, 1'b0, 1'b0));
        step(1'b1, 16'h9E00, 1'b1, 1'b1, mk(16'hFFFF, 1'b0, 1'b0));
`endif
        drain();

        // Backpressure: consumer stalled while 4 items are offered.
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            step(1'b1, bp_vals[idx], 1'b0);
            if (acc) idx++;
            if (c >= 2) begin
                chk("bp_in_ready", in_ready, 1'b0);
                chk("bp_out_valid", out_valid, 1'b1);
                chk("bp_hold_data", out_data, 16'h0100);
            end
        end
        chk("bp_accepted", idx, 2);
        for (int c = 0; c < 20 && idx < 4; c++) begin
            step(1'b1, bp_vals[idx], 1'b1);
            if (acc) idx++;
        end
        chk("bp_all_accepted", idx, 4);
        drain();

        // Random traffic with bubbles and random stalls.
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 3) != 0);
        end
        drain();

        // Reset with two items in flight.
        step(1'b1, 16'h4000, 1'b0);
        step(1'b1, 16'h4200, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_out_data", out_data, 0);
        sb.delete();
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 16'h0000, 1'b1);
            chk("post_rst_quiet", out_valid, 1'b0);
        end
        step(1'b1, 16'h3C00, 1'b1, 1'b1, mk(16'h0100, 1'b0, 1'b0));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
